data_memory: RTL and testbench



---
 rtl/data_memory.sv | 138 +++++++++++++
 tb/tb_data_memory.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: clocked word-addressed storage with a single-outstanding
// valid/ready request/response handshake, byte-lane write strobes, a
// programmable access latency and out-of-range error reporting.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_rw_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    resp_rw_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // A one-bit counter is kept even for LATENCY = 1 so the vector never collapses.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic                    access;
    logic                    in_range;

    // Reset gates both events so a request coinciding with reset is dropped
    // and a write still waiting in BUSY is never committed.
    assign accept   = req_valid_i && req_ready_o;
    assign access   = (state_q == BUSY) && (cnt_q == '0) && !reset;
    assign in_range = {1'b0, addr_q} < DEPTH_C;

    // State and latency counter register; the only state that reset touches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, wait for the consumer in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; response fields read as zero whenever no response is presented.
    always_comb begin
        req_ready_o  = (state_q == IDLE) && !reset;
        resp_valid_o = (state_q == RESP) && !reset;
        resp_rdata_o = resp_valid_o ? rdata_q : '0;
        resp_err_o   = resp_valid_o ? err_q : 1'b0;
        resp_rw_o    = resp_valid_o ? rw_q : 1'b0;
    end

    // Capture the request on acceptance; held unchanged until the next acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= req_rw_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
        end
    end

    // Build the response at the access edge: read data only for in-range reads.
    always_ff @(posedge clk) begin
        if (access) begin
            err_q <= !in_range;
            if (!rw_q && in_range) begin
                rdata_q <= mem_q[addr_q];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    // Storage array write with per-lane strobes; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && rw_q && in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: three instances (LATENCY 2, 1, 4; DEPTH 1000) share
// one request/response stream and are compared against a word-array model.
module tb_data_memory;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_rw;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;

    logic [NI-1:0]        rdy, rv, rerr, rrw;
    logic [NI-1:0][31:0]  rdat;

    int lat_of [NI] = '{2, 1, 4};

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: one word array per instance plus expected response
    logic [31:0] mem_m  [NI][1000];
    logic [31:0] exp_rd [NI];
    logic        exp_err[NI];
    logic        exp_rw [NI];

    data_memory #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(rdy[0]), .req_rw_i(req_rw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .resp_valid_o(rv[0]), .resp_ready_i(resp_ready), .resp_rdata_o(rdat[0]),
        .resp_err_o(rerr[0]), .resp_rw_o(rrw[0])
    );

    data_memory #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(rdy[1]), .req_rw_i(req_rw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .resp_valid_o(rv[1]), .resp_ready_i(resp_ready), .resp_rdata_o(rdat[1]),
        .resp_err_o(rerr[1]), .resp_rw_o(rrw[1])
    );

    data_memory #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(rdy[2]), .req_rw_i(req_rw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .resp_valid_o(rv[2]), .resp_ready_i(resp_ready), .resp_rdata_o(rdat[2]),
        .resp_err_o(rerr[2]), .resp_rw_o(rrw[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // apply one accepted request to the model of instance i
    function automatic void model(input int i, input logic rw, input int a,
                                  input logic [31:0] wd, input logic [3:0] ws);
        exp_rw[i]  = rw;
        exp_err[i] = (a >= 1000);
        exp_rd[i]  = 32'h0;
        if (a < 1000) begin
            if (rw) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mem_m[i][a][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rd[i] = mem_m[i][a];
            end
        end
    endfunction

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (rdy == 3'b111) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", 32'(rdy), 32'h7);
    endtask

    task automatic issue(input logic rw, input int a, input logic [31:0] wd, input logic [3:0] ws);
        wait_idle();
        req_rw    = rw;
        req_addr  = 10'(a);
        req_wdata = wd;
        req_wstrb = ws;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 10'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        for (int i = 0; i < NI; i++) model(i, rw, a, wd, ws);
    endtask

    // collect one response from every instance, with resp_ready high
    task automatic collect();
        logic [NI-1:0] seen;
        seen = '0;
        for (int k = 1; k <= 12 && seen != 3'b111; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && rv[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("latency_L%0d", lat_of[i]), 32'(k), 32'(lat_of[i]));
                    chk($sformatf("rdata_L%0d", lat_of[i]), rdat[i], exp_rd[i]);
                    chk($sformatf("err_L%0d", lat_of[i]), 32'(rerr[i]), 32'(exp_err[i]));
                    chk($sformatf("rw_L%0d", lat_of[i]), 32'(rrw[i]), 32'(exp_rw[i]));
                end
            end
        end
        if (seen != 3'b111) chk("resp_timeout", 32'(seen), 32'h7);
        // the slowest instance returns to IDLE on the following edge
        @(posedge clk); #1;
        chk("ready_after_resp", 32'(rdy), 32'h7);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old3 [NI];
        logic [31:0] snap;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b1;

        // reset held for 3 cycles: everything quiet
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_ready", 32'(rdy), 32'h0);
            chk("rst_valid", 32'(rv), 32'h0);
            chk("rst_err", 32'(rerr), 32'h0);
            chk("rst_rw", 32'(rrw), 32'h0);
            chk("rst_rdata_L2", rdat[0], 32'h0);
            chk("rst_rdata_L4", rdat[2], 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(rdy), 32'h7);

        // give every address that will later be read a known value
        for (int a = 0; a < 16; a++) begin
            issue(1'b1, a, $urandom, 4'hF);
            collect();
        end
        for (int a = 995; a < 1000; a++) begin
            issue(1'b1, a, $urandom, 4'hF);
            collect();
        end

        // full-word write then read
        issue(1'b1, 5, 32'hDEADBEEF, 4'hF); collect();
        issue(1'b0, 5, 32'h0, 4'h0);        collect();

        // byte strobes merge into the existing word
        issue(1'b1, 7, 32'h11223344, 4'hF); collect();
        issue(1'b1, 7, 32'hAABBCCDD, 4'b0101); collect();
        issue(1'b0, 7, 32'h0, 4'h0);        collect();
        chk("strobe_merge_model", mem_m[0][7], 32'h11BB33DD);

        // zero-strobe write still responds and leaves the word alone
        issue(1'b1, 7, 32'h55555555, 4'h0); collect();
        issue(1'b0, 7, 32'h0, 4'h0);        collect();

        // out-of-range write/read and neighbours at both ends
        issue(1'b1, 1000, 32'h12345678, 4'hF); collect();
        issue(1'b0, 1000, 32'h0, 4'h0);        collect();
        issue(1'b0, 0, 32'h0, 4'h0);           collect();
        issue(1'b0, 999, 32'h0, 4'h0);         collect();

        // back-pressure: response held while resp_ready is low
        resp_ready = 1'b0;
        issue(1'b0, 5, 32'h0, 4'h0);
        for (int k = 0; k < 8 && rv != 3'b111; k++) begin
            @(posedge clk); #1;
        end
        chk("bp_all_valid", 32'(rv), 32'h7);
        chk("bp_rdata_first", rdat[0], exp_rd[0]);
        snap = rdat[0];
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                req_valid = 1'b1;
                req_rw    = 1'b0;
                req_addr  = 10'd7;
                req_wstrb = 4'h0;
            end
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(rv), 32'h7);
            chk("bp_rdata_held", rdat[0], snap);
            chk("bp_rdata_L4", rdat[2], exp_rd[2]);
            chk("bp_ready_low", 32'(rdy), 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(rdy), 32'h7);
        chk("bp_release_novalid", 32'(rv), 32'h0);
        // the pending read of addr 7 is taken on this edge
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_pending_taken", 32'(rdy), 32'h0);
        for (int i = 0; i < NI; i++) model(i, 1'b0, 7, 32'h0, 4'h0);
        collect();

        // reset coinciding with a handshake: nothing latched or written
        wait_idle();
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 10'd9;
        req_wdata = 32'h0BADC0DE;
        req_wstrb = 4'hF;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_hs_ready", 32'(rdy), 32'h7);
        chk("rst_hs_novalid", 32'(rv), 32'h0);
        issue(1'b0, 9, 32'h0, 4'h0); collect();

        // reset two cycles after accepting a write: aborted unless already accessed
        for (int i = 0; i < NI; i++) old3[i] = mem_m[i][3];
        issue(1'b1, 3, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1;
        chk("mid_busy_L2_novalid", 32'(rv[0]), 32'h0);
        chk("mid_busy_L4_novalid", 32'(rv[2]), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_busy_rst_valid", 32'(rv), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < NI; i++)
            if (lat_of[i] >= 2) mem_m[i][3] = old3[i];
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("mid_busy_no_resp", 32'(rv), 32'h0);
        end
        issue(1'b0, 3, 32'h0, 4'h0); collect();

        // randomized traffic over the pre-written and out-of-range windows
        for (int t = 0; t < 40; t++) begin
            int a;
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(995, 1023));
            issue(1'($urandom), a, $urandom, 4'($urandom));
            collect();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
